// File: rtl/pill_feeder_if.sv
// Control, configuration and status bundle of the pill feeder.
// The master modport drives the block; the slave modport is the feeder itself.
interface pill_feeder_if;
    logic       start;
    logic       clr;
    logic       pause;
    logic [3:0] maxL;
    logic [3:0] maxH;
    logic [3:0] bottleL;
    logic [3:0] bottleH;
    logic       pill_ready;
    logic       bottle_ack;

    logic       pill_drop;
    logic [3:0] curL;
    logic [3:0] curH;
    logic [3:0] cntL;
    logic [3:0] cntH;
    logic       bottle_req;
    logic       isWork;
    logic       allFull;

    modport master (
        output start, clr, pause, maxL, maxH, bottleL, bottleH, pill_ready, bottle_ack,
        input  pill_drop, curL, curH, cntL, cntH, bottle_req, isWork, allFull
    );

    modport slave (
        input  start, clr, pause, maxL, maxH, bottleL, bottleH, pill_ready, bottle_ack,
        output pill_drop, curL, curH, cntL, cntH, bottle_req, isWork, allFull
    );
endinterface

// File: rtl/pill_feeder.sv
// Pill feeder controller: fills a run of bottles with a fixed BCD pill count,
// spacing drops by GAP_CYC idle cycles and handshaking each bottle swap.
module pill_feeder #(
    parameter int unsigned GAP_CYC = 2
) (
    input logic          CLK,
    input logic          RST_n,
    pill_feeder_if.slave bus
);

    typedef enum logic [2:0] {IDLE, FEED, GAP, SWAP, DONE} state_t;

    state_t     state;
    logic [3:0] max_l, max_h, tgt_l, tgt_h;
    logic [3:0] cur_l, cur_h, cnt_l, cnt_h;
    logic [3:0] gap_cnt;
    logic       pill_drop, bottle_req, is_work, all_full;

    logic       cfg_ok;
    logic [7:0] cur_next, cnt_next;
    logic       cur_at_max, cnt_at_tgt;

    function automatic logic [7:0] bcd_inc(input logic [3:0] h, input logic [3:0] l);
        if (l == 4'd9) return {h + 4'd1, 4'd0};
        else           return {h, l + 4'd1};
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        cfg_ok = (bus.maxL <= 4'd9) && (bus.maxH <= 4'd9) &&
                 (bus.bottleL <= 4'd9) && (bus.bottleH <= 4'd9) &&
                 ({bus.maxH, bus.maxL} != 8'h00) && ({bus.bottleH, bus.bottleL} != 8'h00);
        cur_next   = bcd_inc(cur_h, cur_l);
        cnt_next   = bcd_inc(cnt_h, cnt_l);
        cur_at_max = (cur_next == {max_h, max_l});
        cnt_at_tgt = (cnt_next == {tgt_h, tgt_l});
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= IDLE;
            max_l      <= 4'd0;
            max_h      <= 4'd0;
            tgt_l      <= 4'd0;
            tgt_h      <= 4'd0;
            cur_l      <= 4'd0;
            cur_h      <= 4'd0;
            cnt_l      <= 4'd0;
            cnt_h      <= 4'd0;
            gap_cnt    <= 4'd0;
            pill_drop  <= 1'b0;
            bottle_req <= 1'b0;
            is_work    <= 1'b0;
            all_full   <= 1'b0;
        end else begin
            pill_drop <= 1'b0;
            if (bus.clr) begin
                state      <= IDLE;
                cur_l      <= 4'd0;
                cur_h      <= 4'd0;
                cnt_l      <= 4'd0;
                cnt_h      <= 4'd0;
                gap_cnt    <= 4'd0;
                bottle_req <= 1'b0;
                is_work    <= 1'b0;
                all_full   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && cfg_ok) begin
                            max_l   <= bus.maxL;
                            max_h   <= bus.maxH;
                            tgt_l   <= bus.bottleL;
                            tgt_h   <= bus.bottleH;
                            cur_l   <= 4'd0;
                            cur_h   <= 4'd0;
                            cnt_l   <= 4'd0;
                            cnt_h   <= 4'd0;
                            is_work <= 1'b1;
                            state   <= FEED;
                        end
                    end
                    FEED: begin
                        if (!bus.pause && bus.pill_ready) begin
                            pill_drop      <= 1'b1;
                            {cur_h, cur_l} <= cur_next;
                            if (cur_at_max) begin
                                {cnt_h, cnt_l} <= cnt_next;
                                if (cnt_at_tgt) begin
                                    is_work  <= 1'b0;
                                    all_full <= 1'b1;
                                    state    <= DONE;
                                end else begin
                                    bottle_req <= 1'b1;
                                    state      <= SWAP;
                                end
                            end else if (GAP_CYC != 0) begin
                                gap_cnt <= 4'(GAP_CYC);
                                state   <= GAP;
                            end
                        end
                    end
                    GAP: begin
                        // Countdown freezes while paused, so paused cycles stretch the gap.
                        if (!bus.pause) begin
                            if (gap_cnt <= 4'd1) begin
                                gap_cnt <= 4'd0;
                                state   <= FEED;
                            end else begin
                                gap_cnt <= gap_cnt - 4'd1;
                            end
                        end
                    end
                    SWAP: begin
                        if (bus.bottle_ack) begin
                            cur_l      <= 4'd0;
                            cur_h      <= 4'd0;
                            bottle_req <= 1'b0;
                            state      <= FEED;
                        end
                    end
                    DONE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pill_drop  = pill_drop;
    assign bus.curL       = cur_l;
    assign bus.curH       = cur_h;
    assign bus.cntL       = cnt_l;
    assign bus.cntH       = cnt_h;
    assign bus.bottle_req = bottle_req;
    assign bus.isWork     = is_work;
    assign bus.allFull    = all_full;

endmodule

// File: doc/pill_feeder.md
PILL_FEEDER -- requirements
Module: pill_feeder

Interface
REQ-001 SHALL have parameter GAP_CYC, default 2, meaning idle cycles inserted between consecutive pill drops (range 0..15).
REQ-002 SHALL have port CLK  input  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port RST_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  level; begins a run when sampled high in IDLE.
REQ-005 SHALL have port clr  input  1  synchronous abort/clear to IDLE.
REQ-006 SHALL have port pause  input  1  freezes drops and gap countdown while high.
REQ-007 SHALL have ports maxL, maxH  input  4 each  pills per bottle, BCD units/tens.
REQ-008 SHALL have ports bottleL, bottleH  input  4 each  bottles per run, BCD units/tens.
REQ-009 SHALL have port pill_ready  input  1  a pill is available at the chute.
REQ-010 SHALL have port bottle_ack  input  1  a fresh empty bottle is in place.
REQ-011 SHALL have port pill_drop  output  1  one-cycle pulse per dispensed pill.
REQ-012 SHALL have ports curL, curH  output  4 each  pills in current bottle, BCD.
REQ-013 SHALL have ports cntL, cntH  output  4 each  bottles completed in this run, BCD.
REQ-014 SHALL have ports bottle_req, isWork, allFull  output  1 each  bottle-swap request, run active, run complete.

Function
REQ-015 SHALL implement states IDLE, FEED, GAP, SWAP, DONE; all outputs registered.
REQ-016 IDLE: start high with all four config digits <= 9 and both targets nonzero SHALL latch config, clear cur/cnt, enter FEED next cycle; invalid config SHALL leave block in IDLE.
REQ-017 Config inputs SHALL be ignored after latching until next IDLE exit.
REQ-018 FEED: pause low and pill_ready high SHALL assert pill_drop for exactly one cycle and increment cur (BCD, units 9 -> 0 with tens +1) in the same edge.
REQ-019 After a drop, if new cur != latched max: GAP_CYC = 0 SHALL stay in FEED, else SHALL enter GAP for exactly GAP_CYC cycles (pause-high cycles not counted), then FEED.
REQ-020 After a drop, if new cur == max: cnt SHALL increment (BCD) in the same edge; if new cnt == bottle target, enter DONE, else enter SWAP.
REQ-021 SWAP: bottle_req SHALL be high; bottle_ack high SHALL clear cur, drop bottle_req, and enter FEED on that edge; pause SHALL NOT block ack.
REQ-022 bottle_ack outside SWAP and pill_ready outside FEED SHALL be ignored.
REQ-023 DONE: allFull high, isWork low, cur and cnt held; exit only via clr or reset.
REQ-024 isWork SHALL be high in FEED, GAP, SWAP; low in IDLE and DONE.
REQ-025 clr high SHALL take priority over all other inputs: next state IDLE, cur/cnt cleared, pill_drop/bottle_req/allFull low.
REQ-026 start held high continuously SHALL NOT restart a run from DONE; re-run requires clr then start.
REQ-027 Maximum counts are 99 pills/bottle and 99 bottles; no count SHALL ever exceed its latched target.

Reset
REQ-028 RST_n low SHALL immediately force IDLE, gap counter 0, all outputs 0, independent of CLK.
REQ-029 Reset release SHALL take effect on the first CLK edge with RST_n high; reset mid-run SHALL discard the run.

Verification
REQ-030 max=03, bottles=02, GAP_CYC=2, pill_ready always 1, ack 1 cycle after each req -> drops spaced 3 cycles, 3 drops, bottle_req, cnt=01, 3 drops, DONE with cnt=02, cur=03, allFull=1.
REQ-031 max=12, bottles=01 -> cur sequence 08,09,10,11,12 across units wrap; DONE after 12th drop.
REQ-032 pause high for 5 cycles mid-GAP -> GAP lengthened by exactly 5 cycles, no pill_drop during pause.
REQ-033 maxL=A (invalid) or bottles=00 with start high -> stays IDLE, isWork=0, no drops.
REQ-034 clr asserted in SWAP with bottle_ack simultaneously -> IDLE next cycle, cur=00, cnt=00, bottle_req=0.
REQ-035 RST_n pulsed low between clock edges during FEED -> outputs zero immediately, IDLE, no drop on the following edge.
